// File: rtl/logic_gate_bist.sv
// N-input configurable logic gate with an exhaustive self-test sequencer.
// Optional MISR signature output when GATE_MISR_EN is defined.
module logic_gate_bist #(
  parameter int N_IN  = 2,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [N_IN-1:0]  ext_in,
  input  logic             start,
  input  logic             fault_inj,
  output logic             gate_out,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef GATE_MISR_EN
  output logic [15:0]      signature,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  // state | meaning
  // IDLE  | direct mode, gate_out follows ext_in, waits for start
  // RUN   | applies one vector per cycle, checks the previous one
  // FLUSH | final compare of the last vector, raises done
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t           state, state_nxt;
  logic [2:0]       mode_l;
  logic             gold_q;
  logic             chk_q;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;

  // Gate path: reduction operators.
  function automatic logic gate_f(input logic [2:0] m, input logic [N_IN-1:0] x);
    case (m)
      3'b001:  return |x;
      3'b010:  return ~&x;
      3'b011:  return &x;
      3'b100:  return ^x;
      3'b101:  return ~^x;
      default: return ~|x;
    endcase
  endfunction

  // Golden model: derived from the count of ones, deliberately unlike gate_f.
  function automatic logic gate_t(input logic [2:0] m, input logic [N_IN-1:0] x);
    int ones;
    ones = 0;
    for (int i = 0; i < N_IN; i++) ones += int'(x[i]);
    case (m)
      3'b001:  return ones != 0;
      3'b010:  return ones != N_IN;
      3'b011:  return ones == N_IN;
      3'b100:  return (ones % 2) == 1;
      3'b101:  return (ones % 2) == 0;
      default: return ones == 0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    mismatch  = chk_q && (gate_out != gold_q);
    err_nxt   = err_cnt + CNT_W'(mismatch);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (vec == VEC_LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_l   <= 3'b000;
      gate_out <= 1'b0;
      vec      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      gold_q   <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_cnt <= err_nxt;
      case (state)
        IDLE: begin
          gate_out <= gate_f(mode, ext_in) ^ fault_inj;
          if (start) begin
            mode_l  <= mode;
            vec     <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          gate_out <= gate_f(mode_l, vec) ^ fault_inj;
          gold_q   <= gate_t(mode_l, vec);
          chk_q    <= 1'b1;
          vec      <= vec + 1'b1;
        end
        FLUSH: begin
          chk_q <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_MISR_EN
  // x^16 + x^12 + x^5 + 1, fed with gate_out on every compare edge.
  logic misr_fb;
  assign misr_fb = gate_out ^ signature[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      signature <= 16'h0000;
    else if (state == IDLE && start)
      signature <= 16'hFFFF;
    else if (chk_q)
      signature <= {signature[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);
  end
`endif

endmodule

// File: tb/tb_logic_gate_bist.sv
// Directed bench for logic_gate_bist with N_IN=2 and N_IN=3 instances.
// Signature checks are enabled when GATE_MISR_EN is defined.
module tb_logic_gate_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] mode;
  logic [2:0] ext_in;
  logic       start2, start3, fault_inj;

  logic       g2, b2, dn2, p2;
  logic [1:0] v2;
  logic [2:0] e2;
  logic       g3, b3, dn3, p3;
  logic [2:0] v3;
  logic [3:0] e3;
  logic [15:0] sig2, sig3;

  int tests = 0;
  int fails = 0;
  int vs[0:15];
  int fault_at = -1;
  bit fault_all = 1'b0;
  bit poke = 1'b0;
  int n;
  int k;

  logic_gate_bist #(.N_IN(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in[1:0]), .start(start2),
    .fault_inj(fault_inj), .gate_out(g2), .vec(v2), .busy(b2), .done(dn2), .pass(p2),
`ifdef GATE_MISR_EN
    .signature(sig2),
`endif
    .err_cnt(e2)
  );

  logic_gate_bist #(.N_IN(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in), .start(start3),
    .fault_inj(fault_inj), .gate_out(g3), .vec(v3), .busy(b3), .done(dn3), .pass(p3),
`ifdef GATE_MISR_EN
    .signature(sig3),
`endif
    .err_cnt(e3)
  );

`ifndef GATE_MISR_EN
  assign sig2 = 16'h0000;
  assign sig3 = 16'h0000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference gate: ones-count independent truth table for vector k.
  function automatic logic ref_gate(input int nin, input logic [2:0] m, input int kv);
    logic [7:0] x;
    logic z, o, p;
    x = 8'(kv);
    z = (kv == 0);
    o = (kv == (1 << nin) - 1);
    p = ($countones(x) % 2) == 1;
    case (m)
      3'b001:  return !z;
      3'b010:  return !o;
      3'b011:  return o;
      3'b100:  return p;
      3'b101:  return !p;
      default: return z;
    endcase
  endfunction

  function automatic logic [15:0] misr_ref(input int nin, input logic [2:0] m, input int fat);
    logic [15:0] s;
    logic g, fb;
    s = 16'hFFFF;
    for (int i = 0; i < (1 << nin); i++) begin
      g  = ref_gate(nin, m, i) ^ (i == fat);
      fb = g ^ s[15];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  task automatic do_run(input bit w, output int cnt);
    int cv;
    fault_inj = fault_all;
    if (w) start3 = 1'b1; else start2 = 1'b1;
    tick;
    start2 = 1'b0;
    start3 = 1'b0;
    cnt = 0;
    while ((w ? b3 : b2) === 1'b1 && cnt < 100) begin
      cv = w ? int'(v3) : int'(v2);
      if (cnt < 16) vs[cnt] = cv;
      cnt++;
      fault_inj = fault_all || (cv == fault_at);
      if (poke) begin
        if (cnt == 2) begin start2 = 1'b1; mode = 3'b110; end
        else if (cnt == 3) start2 = 1'b0;
        else if (cnt == 5) start2 = 1'b1;
      end
      tick;
    end
    start2 = 1'b0;
    fault_inj = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 3'b000; ext_in = 3'b000;
    start2 = 1'b0; start3 = 1'b0; fault_inj = 1'b0;
    #3;
    check("rst_gate_out", g2, 0);
    check("rst_vec", v2, 0);
    check("rst_busy", b2, 0);
    check("rst_done", dn2, 0);
    check("rst_pass", p2, 0);
    check("rst_err", e2, 0);
`ifdef GATE_MISR_EN
    check("rst_sig", sig2, 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Direct mode
    mode = 3'b000; ext_in = 3'b000; tick;
    check("dir_nor_00", g2, 1);
    ext_in = 3'b010; tick;
    check("dir_nor_10", g2, 0);
    mode = 3'b100; tick;
    check("dir_xor_10", g2, 1);
    fault_inj = 1'b1; tick;
    check("dir_xor_fault", g2, 0);
    fault_inj = 1'b0; mode = 3'b010; ext_in = 3'b111; tick;
    check("dir_nand3_111", g3, 0);

    // Clean run, N=2 NOR
    mode = 3'b000; do_run(1'b0, n);
    check("clean_busy_len", n, 5);
    for (int i = 0; i < 4; i++) check("clean_vec_seq", vs[i], i);
    check("clean_done", dn2, 1);
    check("clean_pass", p2, 1);
    check("clean_err", e2, 0);
`ifdef GATE_MISR_EN
    check("clean_sig", sig2, misr_ref(2, 3'b000, -1));
`endif

    // Full fault, N=3 XOR
    mode = 3'b100; fault_all = 1'b1; do_run(1'b1, n); fault_all = 1'b0;
    check("full_busy_len", n, 9);
    check("full_err", e3, 8);
    check("full_pass", p3, 0);
    check("full_done", dn3, 1);

    // Single fault at vec=5, N=3 AND
    mode = 3'b011; fault_at = 5; do_run(1'b1, n); fault_at = -1;
    check("single_err", e3, 1);
    check("single_pass", p3, 0);
    check("single_done", dn3, 1);
`ifdef GATE_MISR_EN
    check("single_sig", sig3, misr_ref(3, 3'b011, 5));
    check("single_sig_differs", (sig3 !== misr_ref(3, 3'b011, -1)), 1);
`endif

    // Ignored start/mode during run and start on the FLUSH edge, N=2 AND
    mode = 3'b011; poke = 1'b1; do_run(1'b0, n); poke = 1'b0;
    check("ign_busy_len", n, 5);
    check("ign_err", e2, 0);
    check("ign_pass", p2, 1);
    tick;
    check("ign_flush_start", b2, 0);

    // Mode 110 decodes as NOR
    mode = 3'b110; do_run(1'b0, n);
    check("m110_busy_len", n, 5);
    check("m110_err", e2, 0);
    check("m110_pass", p2, 1);
`ifdef GATE_MISR_EN
    check("m110_sig", sig2, misr_ref(2, 3'b000, -1));
`endif
    ext_in = 3'b001; tick;
    check("m110_direct", g2, 0);

    // Reset mid-run at vec=2
    mode = 3'b000; fault_all = 1'b1; fault_inj = 1'b1;
    start2 = 1'b1; tick; start2 = 1'b0;
    k = 0;
    while (v2 !== 2'd2 && k < 20) begin k++; tick; end
    fault_all = 1'b0;
    check("mid_reached_vec2", v2, 2);
    check("mid_err_before", e2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gate_out", g2, 0);
    check("mid_rst_vec", v2, 0);
    check("mid_rst_busy", b2, 0);
    check("mid_rst_done", dn2, 0);
    check("mid_rst_pass", p2, 0);
    check("mid_rst_err", e2, 0);
`ifdef GATE_MISR_EN
    check("mid_rst_sig", sig2, 0);
`endif
    fault_inj = 1'b0; ext_in = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    tick; tick;
    check("post_rst_busy", b2, 0);
    check("post_rst_done", dn2, 0);
    check("post_rst_idle", g2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
